// File: rtl/sram_port_arbiter.sv
// Arbitrates the inst-fetch and data SRAM-like channels onto one shared port, routing in-order
// responses back through an owner FIFO. Define SRAM_ARB_RR_EN for round-robin instead of data-first priority.
module sram_port_arbiter #(
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [OUTSTANDING-1:0] owner_q;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   lock_vld;
  logic                   lock_owner;

  logic full, empty, owner_req, lock_hit, policy_sel, sel, hs, pop, head;

  assign full      = (count == CNT_W'(OUTSTANDING));
  assign empty     = (count == '0);
  // A lock only pins the grant while its owner is still presenting the request.
  assign owner_req = lock_owner ? data_req : inst_req;
  assign lock_hit  = lock_vld & owner_req;

`ifdef SRAM_ARB_RR_EN
  logic rr_last;

  assign policy_sel = (inst_req & data_req) ? ~rr_last : data_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last <= 1'b0;
    end else if (hs) begin
      rr_last <= sel;
    end
  end
`else
  assign policy_sel = data_req;
`endif

  assign sel     = lock_hit ? lock_owner : policy_sel;
  assign mem_req = (inst_req | data_req) & ~full;
  assign hs      = mem_req & mem_addr_ok;
  assign pop     = mem_data_ok & ~empty;
  assign head    = owner_q[rd_ptr];

  always_comb begin
    mem_wr    = inst_wr;
    mem_size  = inst_size;
    mem_wstrb = inst_wstrb;
    mem_addr  = inst_addr;
    mem_wdata = inst_wdata;
    if (sel) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  assign inst_addr_ok = hs & ~sel;
  assign data_addr_ok = hs & sel;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Grant lock: hold the stalled request until the downstream port takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_vld   <= 1'b0;
      lock_owner <= 1'b0;
    end else if (hs) begin
      lock_vld <= 1'b0;
    end else if (mem_req) begin
      lock_vld   <= 1'b1;
      lock_owner <= sel;
    end else if (lock_vld && !owner_req) begin
      lock_vld <= 1'b0;
    end
  end

  // Owner FIFO of accepted transactions awaiting their in-order response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (hs) begin
        owner_q[wr_ptr] <= sel;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({hs, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
